// File: rtl/najla_ln_pkg.sv
// ---------------------------------------------------------------------------
// najla_ln_pkg
// Shared types and constants for the ln/log10 lookup core.
//   LN_N / LN_IDX_W / LN_FRAC_W : default table depth, index and residue widths
//   LN_LZ_W                     : width of a 128-bit leading-zero count (0..128)
//   LN2_Q30                     : ln(2) rounded to Q2.30, used by the combine stage
//   ln_exp_t                    : signed binary exponent, -64..+63
//   ln_rr_t                     : range-reduced operand handed to the lookup stage
// ---------------------------------------------------------------------------
package najla_ln_pkg;

  localparam int LN_N      = 1024;
  localparam int LN_IDX_W  = $clog2(LN_N);
  localparam int LN_FRAC_W = 16;
  localparam int LN_LZ_W   = 8;

  // round(ln(2) * 2^30)
  localparam logic [31:0] LN2_Q30 = 32'h2C5C_85FE;

  typedef logic signed [7:0] ln_exp_t;

  typedef struct packed {
    logic [LN_IDX_W-1:0]  idx;
    logic [LN_FRAC_W-1:0] frac;
    ln_exp_t              exp;
    logic                 zero;
  } ln_rr_t;

endpackage

// File: rtl/najla_lzc128.sv
// ---------------------------------------------------------------------------
// najla_lzc128
// Combinational 128-bit leading-zero counter.
//   x  : operand
//   lz : number of leading zeros, 0..127, or 128 when x is all zeros
// Built as a balanced tree of 2:1 merges (7 levels), so the depth is
// logarithmic rather than a 128-long priority chain.
// Node numbering: level l occupies [256-(256>>l) .. +(128>>l)-1]; node 0 of
// each level covers the most significant bits.
// ---------------------------------------------------------------------------
module najla_lzc128
  import najla_ln_pkg::*;
(
  input  logic [127:0]         x,
  output logic [LN_LZ_W-1:0]   lz
);

  localparam int NODES = 255;

  logic       z_n [NODES];  // subtree is all zero
  logic [7:0] c_n [NODES];  // leading zeros inside subtree (valid when !z_n)

  always_comb begin
    for (int i = 0; i < NODES; i++) begin
      z_n[i] = 1'b0;
      c_n[i] = 8'd0;
    end
    for (int i = 0; i < 128; i++) begin
      z_n[i] = ~x[127-i];
    end
    for (int l = 1; l < 8; l++) begin
      for (int j = 0; j < (128 >> l); j++) begin
        // hi = left child (more significant), lo = right child.
        // When hi is all zero the count is hi's full width plus lo's count;
        // lo's count is below that width, so an OR forms the sum.
        z_n[256-(256>>l)+j] = z_n[256-(256>>(l-1))+2*j] & z_n[256-(256>>(l-1))+2*j+1];
        c_n[256-(256>>l)+j] = z_n[256-(256>>(l-1))+2*j]
                            ? (8'(1 << (l-1)) | c_n[256-(256>>(l-1))+2*j+1])
                            : c_n[256-(256>>(l-1))+2*j];
      end
    end
  end

  assign lz = z_n[254] ? 8'd128 : c_n[254];

endmodule

// File: rtl/najla_ln_range_reduce.sv
// ---------------------------------------------------------------------------
// najla_ln_range_reduce
// Range-reduces an unsigned Q64.64 operand to 1.m * 2^e for the ln lookup.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : operand handshake, in_x_q64 the Q64.64 operand
//   out_valid/out_ready : result handshake
//   out_idx             : top IDX_W mantissa bits below the leading one
//   out_frac            : next FRAC_W mantissa bits (interpolation fraction)
//   out_exp             : MSB position minus 64, two's complement
//   out_zero            : operand was zero (idx/frac/exp forced to 0)
// Two stages: S1 holds operand + leading-zero count, S2 holds the normalised
// fields. Each stage advances when it is empty or the stage after it drains.
// ---------------------------------------------------------------------------
module najla_ln_range_reduce
  import najla_ln_pkg::*;
#(
  parameter  int N      = LN_N,
  parameter  int FRAC_W = LN_FRAC_W,
  localparam int IDX_W  = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      in_x_q64,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_idx,
  output logic [FRAC_W-1:0] out_frac,
  output ln_exp_t           out_exp,
  output logic              out_zero
);

  // Mantissa bits actually consumed after normalisation.
  localparam logic [127:0] USED_MASK =
    ((128'd1 << (IDX_W + FRAC_W)) - 128'd1) << (127 - IDX_W - FRAC_W);

  logic         v1_reg;
  logic         v2_reg;
  logic [127:0] x1_reg;
  logic [7:0]   lz1_reg;
  logic [7:0]   lz_next;

  logic         adv1;
  logic         adv2;

  logic [127:0] m_next;
  logic         m_unused;

  najla_lzc128 u_lzc (
    .x  (in_x_q64),
    .lz (lz_next)
  );

  assign adv2      = ~v2_reg | out_ready;
  assign adv1      = ~v1_reg | adv2;
  assign in_ready  = adv1;
  assign out_valid = v2_reg;

  // Normalise: the leading one lands on bit 127. A zero operand stays zero,
  // so idx/frac come out as 0 without extra gating.
  assign m_next   = x1_reg << lz1_reg[6:0];
  assign m_unused = ^(m_next & ~USED_MASK);

  // S1: operand and its leading-zero count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_reg  <= 1'b0;
      x1_reg  <= '0;
      lz1_reg <= '0;
    end else if (adv1) begin
      v1_reg <= in_valid;
      if (in_valid) begin
        x1_reg  <= in_x_q64;
        lz1_reg <= lz_next;
      end
    end
  end

  // S2: output fields, frozen while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_reg   <= 1'b0;
      out_idx  <= '0;
      out_frac <= '0;
      out_exp  <= '0;
      out_zero <= 1'b0;
    end else if (adv2) begin
      v2_reg <= v1_reg;
      if (v1_reg) begin
        out_idx  <= m_next[126 -: IDX_W];
        out_frac <= m_next[126-IDX_W -: FRAC_W];
        // exp = (127 - lz) - 64 = 63 - lz, wraps correctly into 8 bits
        out_exp  <= lz1_reg[7] ? ln_exp_t'(8'sd0) : ln_exp_t'(8'd63 - lz1_reg);
        out_zero <= lz1_reg[7];
      end
    end
  end

endmodule

// File: tb/tb_najla_ln_range_reduce.sv
module tb_najla_ln_range_reduce;
  import najla_ln_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_x_q64 = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [9:0]   out_idx;
  logic [15:0]  out_frac;
  ln_exp_t      out_exp;
  logic         out_zero;

  always #5 clk = ~clk;

  najla_ln_range_reduce #(.N(1024), .FRAC_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x_q64  (in_x_q64),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_frac  (out_frac),
    .out_exp   (out_exp),
    .out_zero  (out_zero)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, req);
  endtask

  typedef struct {
    string              name;
    logic [127:0]       x;
    logic [9:0]         idx;
    logic [15:0]        frac;
    logic signed [7:0]  e;
    logic               z;
  } vec_t;

  vec_t vecs [8];

  // Reference: locate the MSB by scanning, then pick bits relative to it.
  function automatic void model(input logic [127:0] x, output logic [9:0] idx,
                                output logic [15:0] frac, output logic signed [7:0] e,
                                output logic z);
    int p;
    int b2;
    p = -1;
    for (int b = 127; b >= 0; b--) if (p < 0 && x[b]) p = b;
    idx = '0; frac = '0; e = '0; z = 1'b0;
    if (p < 0) begin
      z = 1'b1;
    end else begin
      e = 8'(p - 64);
      for (int k = 0; k < 10; k++) begin
        b2 = p - 10 + k;
        if (b2 >= 0) idx[k] = x[b2];
      end
      for (int k = 0; k < 16; k++) begin
        b2 = p - 26 + k;
        if (b2 >= 0) frac[k] = x[b2];
      end
    end
  endfunction

  // Present one operand, measure cycles until out_valid, check fields.
  task automatic run_vec(input vec_t v);
    int lat;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_x_q64 = v.x;
    out_ready = 1'b1;
    #1 chk({v.name, " in_ready"}, 128'(in_ready), 128'(1'b1));
    lat = 0;
    do begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 8);
    chk({v.name, " latency"}, 128'(lat), 128'(2));
    chk({v.name, " idx"},  128'(out_idx),  128'(v.idx));
    chk({v.name, " frac"}, 128'(out_frac), 128'(v.frac));
    chk({v.name, " exp"},  128'(out_exp),  128'(v.e));
    chk({v.name, " zero"}, 128'(out_zero), 128'(v.z));
  endtask

  logic [127:0]      ops [64];
  logic [9:0]        m_idx;
  logic [15:0]       m_frac;
  logic signed [7:0] m_e;
  logic              m_z;

  initial begin
    int rx, first, last, quiet;
    logic [127:0] va, vb, vc;

    vecs[0] = '{"x_1p0",   {64'h1, 64'h0},                  10'd0,    16'h0,    8'sd0,   1'b0};
    vecs[1] = '{"x_3p0",   {64'h3, 64'h0},                  10'd512,  16'h0,    8'sd1,   1'b0};
    vecs[2] = '{"x_lsb",   128'h1,                          10'd0,    16'h0,    -8'sd64, 1'b0};
    vecs[3] = '{"x_ones",  {128{1'b1}},                     10'd1023, 16'hFFFF, 8'sd63,  1'b0};
    vecs[4] = '{"x_zero",  128'h0,                          10'd0,    16'h0,    8'sd0,   1'b1};
    vecs[5] = '{"x_msb",   {1'b1, 127'b0},                  10'd0,    16'h0,    8'sd63,  1'b0};
    vecs[6] = '{"x_frac",  {64'h1, 64'h0060_0000_0000_0000}, 10'd1,   16'h8000, 8'sd0,   1'b0};
    vecs[7] = '{"x_small", 128'h1_8000,                     10'd512,  16'h0,    -8'sd48, 1'b0};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", 128'(out_valid), 128'(1'b0));
    chk("rst fields", 128'({out_zero, out_exp, out_frac, out_idx}), 128'(0));
    rst_n = 1'b1;
    #1 chk("rst in_ready", 128'(in_ready), 128'(1'b1));

    // directed single operands
    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // backpressure: A, B accepted, C held off, A stable at the output
    va = {64'h1, 64'h0};   // exp 0,   idx 0
    vb = {64'h3, 64'h0};   // exp 1,   idx 512
    vc = 128'h1;           // exp -64, idx 0
    @(posedge clk); #1;    // drains the last directed result
    chk("bp drained", 128'(out_valid), 128'(1'b0));
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_x_q64 = va;
    @(posedge clk); #1;
    in_x_q64 = vb;
    chk("bp in_ready B", 128'(in_ready), 128'(1'b1));
    @(posedge clk); #1;
    in_x_q64 = vc;
    chk("bp in_ready C", 128'(in_ready), 128'(1'b0));
    chk("bp valid A", 128'(out_valid), 128'(1'b1));
    chk("bp data A", 128'({out_exp, out_idx}), 128'({8'sd0, 10'd0}));
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk("bp hold valid", 128'(out_valid), 128'(1'b1));
      chk("bp hold A", 128'({out_exp, out_idx}), 128'({8'sd0, 10'd0}));
      chk("bp hold in_ready", 128'(in_ready), 128'(1'b0));
    end
    out_ready = 1'b1;
    #1 chk("bp release in_ready", 128'(in_ready), 128'(1'b1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp valid B", 128'(out_valid), 128'(1'b1));
    chk("bp data B", 128'({out_exp, out_idx}), 128'({8'sd1, 10'd512}));
    @(posedge clk); #1;
    chk("bp valid C", 128'(out_valid), 128'(1'b1));
    chk("bp data C", 128'({out_exp, out_idx}), 128'({-8'sd64, 10'd0}));
    @(posedge clk); #1;
    chk("bp empty", 128'(out_valid), 128'(1'b0));

    // throughput: 64 operands back-to-back
    for (int i = 0; i < 64; i++) begin
      ops[i] = {$urandom, $urandom, $urandom, $urandom} >> $urandom_range(0, 127);
    end
    ops[10] = '0;
    ops[20] = {128{1'b1}};
    ops[30] = 128'h1;
    rx = 0; first = -1; last = -1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 72; cyc++) begin
      if (out_valid) begin
        if (rx < 64) begin
          model(ops[rx], m_idx, m_frac, m_e, m_z);
          chk($sformatf("thru op%0d", rx),
              128'({out_zero, out_exp, out_frac, out_idx}),
              128'({m_z, m_e, m_frac, m_idx}));
        end
        if (first < 0) first = cyc;
        last = cyc;
        rx++;
      end
      if (cyc < 64) begin
        in_valid = 1'b1;
        in_x_q64 = ops[cyc];
      end else begin
        in_valid = 1'b0;
        in_x_q64 = '0;
      end
      @(posedge clk); #1;
    end
    chk("thru count", 128'(rx), 128'(64));
    chk("thru first cycle", 128'(first), 128'(2));
    chk("thru span", 128'(last - first), 128'(63));

    // reset with both stages full
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_x_q64 = vb;
    @(posedge clk); #1;
    in_x_q64 = va;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mid full valid", 128'(out_valid), 128'(1'b1));
    chk("mid full data", 128'({out_exp, out_idx}), 128'({8'sd1, 10'd512}));
    #2 rst_n = 1'b0;
    #1;
    chk("async rst valid", 128'(out_valid), 128'(1'b0));
    chk("async rst fields", 128'({out_zero, out_exp, out_frac, out_idx}), 128'(0));
    @(posedge clk); #1;
    out_ready = 1'b1;
    rst_n = 1'b1;
    quiet = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) quiet++;
    end
    chk("post rst quiet", 128'(quiet), 128'(0));
    run_vec(vecs[1]);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
